// File: rtl/ex_div_sequencer.sv
// ex_div_sequencer: multi-cycle radix-2 restoring divider with sequencing FSM; optional DIV_EARLY_EXIT_EN shortcut
module ex_div_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  div_req_valid,
    output logic                  div_req_ready,
    input  logic                  div_op_mod,
    input  logic                  div_signed,
    input  logic [DATA_WIDTH-1:0] div_src1,
    input  logic [DATA_WIDTH-1:0] div_src2,
    input  logic [4:0]            div_dest,
    output logic                  div_res_valid,
    input  logic                  div_res_ready,
    output logic [DATA_WIDTH-1:0] div_result,
    output logic [4:0]            div_res_dest,
    output logic                  div_busy
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    state_t                state_q, state_d;
    logic                  mod_q, mod_d, qs_q, qs_d, rs_q, rs_d, div0_q, div0_d, skip_q, skip_d;
    logic [4:0]            dest_q, dest_d, res_dest_q, res_dest_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d, dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, result_q, result_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] abs1, abs2, qv, rv;
    logic [DATA_WIDTH:0]   shifted;
    logic                  ge;
    assign div_req_ready = state_q == IDLE;
    assign div_res_valid = state_q == DONE;
    assign div_busy      = state_q != IDLE;
    assign div_result    = result_q;
    assign div_res_dest  = res_dest_q;
    // next-state, restoring step and result fix-up
    always_comb begin
        state_d    = state_q;
        mod_d      = mod_q;
        qs_d       = qs_q;
        rs_d       = rs_q;
        div0_d     = div0_q;
        skip_d     = skip_q;
        dest_d     = dest_q;
        src1_d     = src1_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        res_dest_d = res_dest_q;
        abs1       = (div_signed && div_src1[DATA_WIDTH-1]) ? -div_src1 : div_src1;
        abs2       = (div_signed && div_src2[DATA_WIDTH-1]) ? -div_src2 : div_src2;
        shifted    = {rem_q, dvd_q[DATA_WIDTH-1]};
        ge         = shifted >= {1'b0, dvs_q};
        qv         = qs_q ? -dvd_q : dvd_q;
        rv         = rs_q ? -rem_q : rem_q;
        case (state_q)
            IDLE: if (div_req_valid && !flush) begin
                mod_d  = div_op_mod;
                qs_d   = div_signed && (div_src1[DATA_WIDTH-1] ^ div_src2[DATA_WIDTH-1]);
                rs_d   = div_signed && div_src1[DATA_WIDTH-1];
                div0_d = div_src2 == '0;
                dest_d = div_dest;
                src1_d = div_src1;
                dvs_d  = abs2;
                dvd_d  = abs1;
                rem_d  = '0;
                cnt_d  = '0;
                skip_d = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
                // quotient is already known to be zero; the remainder is the whole dividend
                if (div_src2 == '0 || abs1 < abs2) begin
                    skip_d = 1'b1;
                    dvd_d  = '0;
                    rem_d  = abs1;
                end
`endif
                state_d = CALC;
            end
            CALC: if (skip_q) state_d = FIX;
            else begin
                rem_d = ge ? shifted[DATA_WIDTH-1:0] - dvs_q : shifted[DATA_WIDTH-1:0];
                dvd_d = {dvd_q[DATA_WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                state_d = cnt_q == LAST ? FIX : CALC;
            end
            FIX: begin
                result_d   = mod_q ? (div0_q ? src1_q : rv) : (div0_q ? '1 : qv);
                res_dest_d = dest_q;
                state_d    = DONE;
            end
            default: state_d = div_res_ready ? IDLE : DONE;
        endcase
        if (flush) state_d = IDLE;
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mod_q      <= 1'b0;
            qs_q       <= 1'b0;
            rs_q       <= 1'b0;
            div0_q     <= 1'b0;
            skip_q     <= 1'b0;
            dest_q     <= '0;
            src1_q     <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            res_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            mod_q      <= mod_d;
            qs_q       <= qs_d;
            rs_q       <= rs_d;
            div0_q     <= div0_d;
            skip_q     <= skip_d;
            dest_q     <= dest_d;
            src1_q     <= src1_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            res_dest_q <= res_dest_d;
        end
    end
endmodule

// File: tb/tb_ex_div_sequencer.sv
// tb_ex_div_sequencer: scoreboard bench for ex_div_sequencer (latency, handshake, flush, reset, boundaries)
module tb_ex_div_sequencer;
    localparam int W = 32;
    logic          clk = 1'b0;
    logic          reset = 1'b1, flush = 1'b0, div_req_valid = 1'b0, div_op_mod = 1'b0, div_signed = 1'b0;
    logic          div_res_ready = 1'b0;
    logic [W-1:0]  div_src1 = '0, div_src2 = '0;
    logic [4:0]    div_dest = '0;
    logic          div_req_ready, div_res_valid, div_busy;
    logic [W-1:0]  div_result;
    logic [4:0]    div_res_dest;
    typedef struct packed {logic [31:0] res; logic [4:0] dest;} exp_t;
    exp_t          sb[$];
    int            n_cmp = 0, n_err = 0;

    ex_div_sequencer dut (
        .clk(clk), .reset(reset), .flush(flush),
        .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
        .div_op_mod(div_op_mod), .div_signed(div_signed),
        .div_src1(div_src1), .div_src2(div_src2), .div_dest(div_dest),
        .div_res_valid(div_res_valid), .div_res_ready(div_res_ready),
        .div_result(div_result), .div_res_dest(div_res_dest), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic m, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return m ? a : 32'hFFFF_FFFF;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'h0 : 32'h8000_0000;
            return m ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return m ? a % b : a / b;
    endfunction

    function automatic int lat_of(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
        logic [31:0] aa, ab;
        aa = (s && a[31]) ? -a : a;
        ab = (s && b[31]) ? -b : b;
        if (b == 0 || aa < ab) return 2;
`endif
        return W + 1;
    endfunction

    task automatic start(input logic m, input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        @(negedge clk);
        check("req_ready_idle", 32'(div_req_ready), 1);
        div_req_valid = 1'b1;
        div_op_mod = m;
        div_signed = s;
        div_src1 = a;
        div_src2 = b;
        div_dest = d;
        @(negedge clk);
        div_req_valid = 1'b0;
    endtask

    task automatic run_op(input logic m, input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, input int hold);
        exp_t e;
        int lat, gaps;
        logic [31:0] r0;
        sb.push_back('{res: model(m, s, a, b), dest: d});
        start(m, s, a, b, d);
        lat = 0;
        gaps = 0;
        while (!div_res_valid && lat < 200) begin
            if (!div_busy || div_req_ready) gaps++;
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(lat_of(s, a, b)));
        check("busy_gap", 32'(gaps), 0);
        check("sb_size", 32'(sb.size()), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result", div_result, e.res);
            check("dest", 32'(div_res_dest), 32'(e.dest));
        end
        r0 = div_result;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 32'(div_res_valid), 1);
            check("hold_result", div_result, r0);
            check("hold_req_ready", 32'(div_req_ready), 0);
            check("hold_busy", 32'(div_busy), 1);
        end
        div_res_ready = 1'b1;
        @(negedge clk);
        div_res_ready = 1'b0;
        check("post_valid", 32'(div_res_valid), 0);
        check("post_req_ready", 32'(div_req_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_req_ready", 32'(div_req_ready), 1);
        check("rst_res_valid", 32'(div_res_valid), 0);
        check("rst_busy", 32'(div_busy), 0);
        check("rst_result", div_result, 0);
        check("rst_res_dest", 32'(div_res_dest), 0);

        run_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd9, 0);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0);
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
        run_op(1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 0);
        run_op(1'b1, 1'b0, 32'h1234, 32'h0, 5'd8, 0);
        run_op(1'b0, 1'b1, 32'h1234, 32'h0, 5'd10, 0);
        run_op(1'b1, 1'b1, 32'hFFFF_EDCC, 32'h0, 5'd11, 0);
        run_op(1'b0, 1'b0, 32'd3, 32'd9, 5'd12, 0);
        run_op(1'b1, 1'b0, 32'd3, 32'd9, 5'd13, 0);
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd14, 0);
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 5'd15, 0);
        run_op(1'b1, 1'b0, 32'd1000, 32'd33, 5'd31, 10);

        start(1'b0, 1'b0, 32'd100, 32'd7, 5'd1);
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(div_busy), 0);
        check("flush_req_ready", 32'(div_req_ready), 1);
        highs = 0;
        repeat (40) begin
            if (div_res_valid) highs++;
            @(negedge clk);
        end
        check("flush_no_valid", 32'(highs), 0);

        div_req_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        div_req_valid = 1'b0;
        flush = 1'b0;
        check("flush_req_busy", 32'(div_busy), 0);
        check("flush_req_ready", 32'(div_req_ready), 1);

        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd2, 0);

        sb.push_back('{res: model(1'b0, 1'b0, 32'd50, 32'd5), dest: 5'd16});
        start(1'b0, 1'b0, 32'd50, 32'd5, 5'd16);
        repeat (60) if (!div_res_valid) @(negedge clk);
        e_chk: begin
            exp_t e;
            e = sb.pop_front();
            check("done_flush_result", div_result, e.res);
        end
        flush = 1'b1;
        div_res_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        div_res_ready = 1'b0;
        check("done_flush_valid", 32'(div_res_valid), 0);
        check("done_flush_ready", 32'(div_req_ready), 1);

        start(1'b0, 1'b0, 32'd77, 32'd3, 5'd20);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(div_busy), 0);
        check("midrst_result", div_result, 0);
        check("midrst_dest", 32'(div_res_dest), 0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (i % 6 == 5) a = $urandom_range(0, 40);
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, 5'($urandom_range(0, 31)), i % 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
